// File: rtl/sm1153_adc_sensor_scan.sv
`default_nettype none
// ============================================================================
// Module   : sm1153_adc_sensor_scan
// Purpose  : ADC128S022 SPI master that round-robins three line-sensor
//            channels and publishes all three results together once per scan.
// Revision : 1.0  initial release
// ============================================================================

module sm1153_adc_sensor_scan #(
  parameter int         CLK_DIV_HALF   = 10,
  parameter int         CS_HIGH_CYCLES = 20,
  parameter logic [2:0] CH_SLOT0       = 3'd3,
  parameter logic [2:0] CH_SLOT1       = 3'd4,
  parameter logic [2:0] CH_SLOT2       = 3'd5
) (
  input  logic        clk_50,
  input  logic        reset,
  output logic        adc_cs_n,
  output logic        adc_sck,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] input1,
  output logic [11:0] input2,
  output logic [11:0] input3,
  output logic        sample_valid
);

  localparam int CNT_MAX = (CLK_DIV_HALF > CS_HIGH_CYCLES) ? CLK_DIV_HALF : CS_HIGH_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CS_HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV_HALF - 1);
  localparam logic [3:0]       LAST_BIT   = 4'd15;
  localparam logic [3:0]       FIRST_DATA = 4'd4;

  typedef enum logic [0:0] {
    GAP   = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [3:0]       bit_idx, bit_idx_nx;
  logic             cs_n_nx, sck_nx, din_nx;
  logic [11:0]      rx_shift, rx_shift_nx;
  logic [11:0]      shadow0, shadow0_nx;
  logic [11:0]      shadow1, shadow1_nx;
  logic [11:0]      input1_nx, input2_nx, input3_nx;
  logic             valid_nx;
  logic [1:0]       slot, slot_nx;
  logic             priming, priming_nx;
  logic [2:0]       tx_addr;

  // Control word: ADD2..ADD0 occupy bit positions 2..4, everything else is 0.
  function automatic logic din_bit(input logic [3:0] idx, input logic [2:0] addr);
    case (idx)
      4'd2:    din_bit = addr[2];
      4'd3:    din_bit = addr[1];
      4'd4:    din_bit = addr[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  // The ADC converts the address of the previous frame, so each frame requests
  // the channel of the slot after the one whose data it is receiving.
  assign tx_addr = priming     ? CH_SLOT0 :
                   (slot == 2'd0) ? CH_SLOT1 :
                   (slot == 2'd1) ? CH_SLOT2 : CH_SLOT0;

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    cs_n_nx     = adc_cs_n;
    sck_nx      = adc_sck;
    din_nx      = adc_din;
    rx_shift_nx = rx_shift;
    shadow0_nx  = shadow0;
    shadow1_nx  = shadow1;
    input1_nx   = input1;
    input2_nx   = input2;
    input3_nx   = input3;
    valid_nx    = 1'b0;
    slot_nx     = slot;
    priming_nx  = priming;

    case (state)
      GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx   = FRAME;
          cnt_nx     = '0;
          bit_idx_nx = 4'd0;
          cs_n_nx    = 1'b0;
          sck_nx     = 1'b0;
          din_nx     = din_bit(4'd0, tx_addr);
        end else begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end

      FRAME: begin
        if (cnt != HALF_LAST) begin
          cnt_nx = cnt + CNT_W'(1);
        end else begin
          cnt_nx = '0;
          if (!adc_sck) begin
            // Rising SCLK: capture DOUT, skipping the four leading bits.
            sck_nx = 1'b1;
            if (bit_idx >= FIRST_DATA) begin
              rx_shift_nx = {rx_shift[10:0], adc_dout};
            end
          end else if (bit_idx != LAST_BIT) begin
            sck_nx     = 1'b0;
            bit_idx_nx = bit_idx + 4'd1;
            din_nx     = din_bit(bit_idx + 4'd1, tx_addr);
          end else begin
            state_nx = GAP;
            cs_n_nx  = 1'b1;
            if (priming) begin
              priming_nx = 1'b0;
            end else begin
              case (slot)
                2'd0:    shadow0_nx = rx_shift;
                2'd1:    shadow1_nx = rx_shift;
                default: begin
                  input1_nx = shadow0;
                  input2_nx = shadow1;
                  input3_nx = rx_shift;
                  valid_nx  = 1'b1;
                end
              endcase
              slot_nx = (slot == 2'd2) ? 2'd0 : slot + 2'd1;
            end
          end
        end
      end

      default: begin
        state_nx = GAP;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      state        <= GAP;
      cnt          <= '0;
      bit_idx      <= 4'd0;
      adc_cs_n     <= 1'b1;
      adc_sck      <= 1'b1;
      adc_din      <= 1'b0;
      rx_shift     <= 12'd0;
      shadow0      <= 12'd0;
      shadow1      <= 12'd0;
      input1       <= 12'd0;
      input2       <= 12'd0;
      input3       <= 12'd0;
      sample_valid <= 1'b0;
      slot         <= 2'd0;
      priming      <= 1'b1;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      bit_idx      <= bit_idx_nx;
      adc_cs_n     <= cs_n_nx;
      adc_sck      <= sck_nx;
      adc_din      <= din_nx;
      rx_shift     <= rx_shift_nx;
      shadow0      <= shadow0_nx;
      shadow1      <= shadow1_nx;
      input1       <= input1_nx;
      input2       <= input2_nx;
      input3       <= input3_nx;
      sample_valid <= valid_nx;
      slot         <= slot_nx;
      priming      <= priming_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sm1153_adc_sensor_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_sm1153_adc_sensor_scan
// Purpose  : Scoreboard bench with an ADC128S022 behavioural model.
// Revision : 1.0  initial release
// ============================================================================

module tb_sm1153_adc_sensor_scan;

  logic        clk_50   = 1'b0;
  logic        reset    = 1'b1;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sck, adc_din, sample_valid;
  logic [11:0] input1, input2, input3;

  always #5 clk_50 = ~clk_50;

  sm1153_adc_sensor_scan dut (
    .clk_50       (clk_50),
    .reset        (reset),
    .adc_cs_n     (adc_cs_n),
    .adc_sck      (adc_sck),
    .adc_din      (adc_din),
    .adc_dout     (adc_dout),
    .input1       (input1),
    .input2       (input2),
    .input3       (input3),
    .sample_valid (sample_valid)
  );

  int          total = 0;
  int          fails = 0;
  int          cyc = 0;
  int          pulses = 0;
  int          rst_cyc = 0;
  int          last_pulse_cyc = 0;
  bit          first_after_reset = 1'b1;
  bit          hold_ok = 1'b1;
  logic [35:0] held = '0;
  logic [35:0] exp_q[$];
  logic [11:0] ch_val [8];
  logic [3:0]  lead = 4'h0;

  always @(posedge clk_50) cyc <= cyc + 1;

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model + SPI timing / address checker ----------------
  logic [2:0]  seq [3] = '{3'd3, 3'd4, 3'd5};
  bit          in_frame = 1'b0;
  bit          gap_seen = 1'b0;
  bit          gap_ok = 1'b1;
  logic        prev_cs = 1'b1;
  logic        prev_sck = 1'b1;
  int          bit_i = 0, rises = 0, phase_len = 0, phase_err = 0, gap_len = 0, addr_idx = 0;
  logic [2:0]  addr_bits = '0;
  logic [2:0]  last_addr = '0;
  logic [15:0] word = '0;

  always @(negedge clk_50) begin
    if (reset) begin
      in_frame = 1'b0;
      gap_seen = 1'b0;
      addr_idx = 0;
    end else if (prev_cs && !adc_cs_n) begin
      if (gap_seen) check("cs_gap_ge20_sck_high", 48'(gap_len >= 20 && gap_ok), 48'd1);
      in_frame  = 1'b1;
      bit_i     = 0;
      rises     = 0;
      phase_len = 1;
      phase_err = 0;
      addr_bits = '0;
      word      = {lead, ch_val[last_addr]};
      adc_dout  = word[15];
    end else if (!prev_cs && adc_cs_n) begin
      if (in_frame) begin
        if (phase_len != 10) phase_err++;
        check("frame_sclk_rises", 48'(rises), 48'd16);
        check("frame_phase_errors", 48'(phase_err), 48'd0);
        check("din_address", 48'(addr_bits), 48'(seq[addr_idx % 3]));
        addr_idx++;
        last_addr = addr_bits;
        gap_seen  = 1'b1;
      end
      in_frame = 1'b0;
      gap_len  = 1;
      gap_ok   = adc_sck;
    end else if (in_frame) begin
      if (adc_sck != prev_sck) begin
        if (phase_len != 10) phase_err++;
        phase_len = 1;
        if (adc_sck) begin
          rises++;
          if (bit_i >= 2 && bit_i <= 4) addr_bits[4 - bit_i] = adc_din;
        end else begin
          bit_i++;
          adc_dout = word[15 - bit_i];
        end
      end else begin
        phase_len++;
      end
    end else if (adc_cs_n) begin
      gap_len++;
      if (!adc_sck) gap_ok = 1'b0;
    end
    prev_cs  = adc_cs_n;
    prev_sck = adc_sck;
  end

  // ---------------- Monitor: pops the scoreboard on each pulse ----------------
  logic [35:0] got, want;
  always @(negedge clk_50) begin
    if (reset) begin
      held = '0;
    end else if (sample_valid) begin
      got = {input1, input2, input3};
      if (exp_q.size() == 0) begin
        total++;
        fails++;
        $display("FAIL unexpected_sample_valid: got %h, expected no pulse", got);
      end else begin
        want = exp_q.pop_front();
        check("scan_result", 48'(got), 48'(want));
      end
      check("hold_between_pulses", 48'(hold_ok), 48'd1);
      if (first_after_reset) check("first_pulse_delay", 48'(cyc - rst_cyc), 48'd1360);
      else                   check("pulse_spacing", 48'(cyc - last_pulse_cyc), 48'd1020);
      first_after_reset = 1'b0;
      last_pulse_cyc    = cyc;
      held              = got;
      hold_ok           = 1'b1;
      pulses++;
    end else if ({input1, input2, input3} !== held) begin
      hold_ok = 1'b0;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic set_scan(input logic [3:0] ld, input logic [11:0] a, input logic [11:0] b,
                          input logic [11:0] c);
    lead      = ld;
    ch_val[3] = a;
    ch_val[4] = b;
    ch_val[5] = c;
    exp_q.push_back({a, b, c});
  endtask

  task automatic wait_pulse(input int bound);
    int start;
    int n;
    start = pulses;
    n = 0;
    while (pulses == start && n < bound) begin
      @(posedge clk_50);
      n++;
    end
    #1;
    if (pulses == start) begin
      total++;
      fails++;
      $display("FAIL pulse_timeout: got none in %0d cycles, expected a pulse", bound);
    end
  endtask

  task automatic wait_cs_fall(input int bound);
    int n;
    n = 0;
    while (adc_cs_n !== 1'b1 && n < bound) begin @(posedge clk_50); #1; n++; end
    while (adc_cs_n !== 1'b0 && n < bound) begin @(posedge clk_50); #1; n++; end
    if (adc_cs_n !== 1'b0) begin
      total++;
      fails++;
      $display("FAIL cs_fall_timeout: got cs_n=%b, expected 0", adc_cs_n);
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 8; i++) ch_val[i] = 12'h000;
    set_scan(4'h0, 12'h123, 12'h9AB, 12'h456);

    for (int i = 0; i < 5; i++) begin
      @(posedge clk_50); #1;
      check("reset_outputs",
            {8'd0, adc_cs_n, adc_sck, adc_din, sample_valid, input1, input2, input3},
            {8'd0, 4'b1100, 36'd0});
    end
    reset = 1'b0;
    rst_cyc = cyc;
    first_after_reset = 1'b1;

    n = 0;
    while (adc_cs_n !== 1'b0 && n < 100) begin @(posedge clk_50); #1; n++; end
    check("first_cs_fall_delay", 48'(cyc - rst_cyc), 48'd20);

    wait_pulse(1500);
    set_scan(4'hF, 12'hFFF, 12'h000, 12'hFFF);
    wait_pulse(1100);
    set_scan(4'hF, 12'h000, 12'hFFF, 12'h000);
    wait_pulse(1100);
    set_scan(4'hA, 12'h800, 12'h001, 12'hA5A);
    wait_pulse(1100);

    // Abort the slot-1 frame of the next scan at its 150th cycle.
    wait_cs_fall(400);
    wait_cs_fall(400);
    repeat (149) @(posedge clk_50);
    #1;
    reset = 1'b1;
    @(posedge clk_50); #1;
    check("midframe_reset_outputs",
          {8'd0, adc_cs_n, adc_sck, adc_din, sample_valid, input1, input2, input3},
          {8'd0, 4'b1100, 36'd0});
    reset = 1'b0;
    rst_cyc = cyc;
    first_after_reset = 1'b1;
    set_scan(4'h0, 12'h321, 12'h654, 12'h987);
    wait_pulse(1500);
    set_scan(4'h3, 12'h0F0, 12'h7FF, 12'h001);
    wait_pulse(1100);

    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    repeat (5) @(posedge clk_50);
    $display("[TB] %0d tests run, %0d failed", total, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
